display_scan_controller: RTL

- Scans the double-buffered display memory and drives a HUB75-style LED panel using binary-coded modulation (BCM) bit planes.
- Issues read addresses (rrow, rcol) to the memory and consumes rdata. Owns the memory's flip select.
- Arbitrates buffer swaps requested by the frame writer; a swap is only ever committed at a frame boundary.
- Sits between display_memory and the panel pins.

---
 rtl/display_scan_controller.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Reads the front buffer of a double-buffered display memory row by row.
// It drives a HUB75-style LED panel using binary-coded modulation: each row is
// shifted out once per bit plane, latched, and then lit for a time that doubles
// with each plane. The block owns the memory's flip select. A buffer swap
// requested by the frame writer is only committed at a frame boundary, so one
// frame never mixes the two buffers.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   enable      run the scan; sampled in IDLE and at frame boundaries
//   swap_req    writer requests a buffer swap (level or pulse)
//   swap_ack    one-cycle pulse when a swap is committed
//   flip        front-buffer select to the memory
//   rrow, rcol  memory read address; rdata is valid one cycle later
//   rdata       memory read data, one 24-bit {R,G,B} word per segment
//   addr        panel row address
//   rgb         panel data, segment s on bits [3s+2:3s] as {r,g,b}
//   sclk        panel shift clock
//   latch       panel latch pulse
//   oe_n        panel output enable, active low
module display_scan_controller #(
    parameter int segments    = 1,
    parameter int rows        = 8,
    parameter int columns     = 32,
    parameter int width       = 24,
    parameter int depth       = 8,
    parameter int base_cycles = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          flip,
    output logic [$clog2(rows)-1:0]       rrow,
    output logic [$clog2(columns)-1:0]    rcol,
    input  logic [width*segments-1:0]     rdata,
    output logic [$clog2(rows)-1:0]       addr,
    output logic [3*segments-1:0]         rgb,
    output logic                          sclk,
    output logic                          latch,
    output logic                          oe_n
);

    localparam int row_w      = $clog2(rows);
    localparam int col_w      = $clog2(columns);
    localparam int shift_last = 2 * columns + 1;
    localparam int disp_max   = base_cycles << (depth - 1);
    localparam int cnt_max    = (shift_last > disp_max) ? shift_last : disp_max;
    localparam int cnt_w      = $clog2(cnt_max + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        BLANK,
        DISPLAY
    } state_t;

    state_t                state_reg;
    logic [cnt_w-1:0]      cnt_reg;
    logic [row_w-1:0]      row_reg;
    logic [2:0]            plane_reg;
    logic                  pending_reg;
    logic                  flip_reg;
    logic                  swap_ack_reg;
    logic                  oe_n_reg;
    logic                  latch_reg;
    logic                  sclk_reg;
    logic [row_w-1:0]      addr_reg;
    logic [row_w-1:0]      rrow_reg;
    logic [col_w-1:0]      rcol_reg;
    logic [3*segments-1:0] rgb_reg;

    logic [cnt_w-1:0]      cnt_inc;
    logic [cnt_w-1:0]      disp_last;
    logic                  plane_last;
    logic                  row_last;
    logic                  frame_end;
    logic [2:0]            plane_next;
    logic [row_w-1:0]      row_next;
    logic [3*segments-1:0] pix_bits;

    assign cnt_inc   = cnt_reg + cnt_w'(1);
    // Plane p is lit for base_cycles << p clocks; the counter runs 0..len-1.
    assign disp_last = cnt_w'((base_cycles << plane_reg) - 1);

    always_comb begin
        plane_last = (plane_reg == 3'(depth - 1));
        row_last   = (row_reg == row_w'(rows - 1));
        plane_next = plane_last ? 3'd0 : plane_reg + 3'd1;
        row_next   = row_reg;
        if (plane_last) begin
            row_next = row_last ? '0 : row_reg + row_w'(1);
        end
    end

    assign frame_end = plane_last & row_last;

    // Select the current bit plane of each channel for every segment.
    genvar gi;
    generate
        for (gi = 0; gi < segments; gi++) begin : g_seg
            logic [width-1:0] word;
            logic [7:0]       r_ch;
            logic [7:0]       g_ch;
            logic [7:0]       b_ch;
            assign word = rdata[width*gi +: width];
            assign r_ch = word[23:16];
            assign g_ch = word[15:8];
            assign b_ch = word[7:0];
            assign pix_bits[3*gi+2] = r_ch[plane_reg];
            assign pix_bits[3*gi+1] = g_ch[plane_reg];
            assign pix_bits[3*gi]   = b_ch[plane_reg];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            row_reg      <= '0;
            plane_reg    <= '0;
            pending_reg  <= 1'b0;
            flip_reg     <= 1'b0;
            swap_ack_reg <= 1'b0;
            oe_n_reg     <= 1'b1;
            latch_reg    <= 1'b0;
            sclk_reg     <= 1'b0;
            addr_reg     <= '0;
            rrow_reg     <= '0;
            rcol_reg     <= '0;
            rgb_reg      <= '0;
        end else begin
            swap_ack_reg <= 1'b0;
            // Any request is remembered until the next frame boundary.
            pending_reg  <= pending_reg | swap_req;

            case (state_reg)
                IDLE: begin
                    oe_n_reg <= 1'b1;
                    if (enable) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= '0;
                        row_reg   <= '0;
                        plane_reg <= '0;
                        rrow_reg  <= '0;
                        rcol_reg  <= '0;
                        sclk_reg  <= 1'b0;
                    end
                end

                SHIFT: begin
                    // Shift cycle k: rcol = k/2 is issued, so the data for
                    // column c arrives in cycle 2c+1 and is presented on rgb
                    // in cycle 2c+2, with sclk high in cycle 2c+3.
                    if (cnt_reg == cnt_w'(shift_last)) begin
                        state_reg <= BLANK;
                        cnt_reg   <= '0;
                        oe_n_reg  <= 1'b1;
                        sclk_reg  <= 1'b0;
                    end else begin
                        cnt_reg  <= cnt_inc;
                        sclk_reg <= cnt_inc[0] && (cnt_inc >= cnt_w'(2));
                        if (cnt_inc < cnt_w'(2 * columns)) begin
                            rcol_reg <= col_w'(cnt_inc >> 1);
                        end
                        if (!cnt_inc[0] && (cnt_inc >= cnt_w'(2))) begin
                            rgb_reg <= pix_bits;
                        end
                    end
                end

                BLANK: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_reg == cnt_w'(0)) begin
                        latch_reg <= 1'b1;
                        addr_reg  <= row_reg;
                    end else if (cnt_reg == cnt_w'(1)) begin
                        latch_reg <= 1'b0;
                    end else begin
                        state_reg <= DISPLAY;
                        cnt_reg   <= '0;
                        oe_n_reg  <= 1'b0;
                    end
                end

                DISPLAY: begin
                    if (cnt_reg == disp_last) begin
                        oe_n_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        plane_reg <= plane_next;
                        row_reg   <= row_next;
                        rrow_reg  <= row_next;
                        rcol_reg  <= '0;
                        sclk_reg  <= 1'b0;
                        if (frame_end) begin
                            // A request arriving on this very cycle is honoured too.
                            if (pending_reg || swap_req) begin
                                flip_reg     <= ~flip_reg;
                                swap_ack_reg <= 1'b1;
                                pending_reg  <= 1'b0;
                            end
                            state_reg <= enable ? SHIFT : IDLE;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign swap_ack = swap_ack_reg;
    assign flip     = flip_reg;
    assign rrow     = rrow_reg;
    assign rcol     = rcol_reg;
    assign addr     = addr_reg;
    assign rgb      = rgb_reg;
    assign sclk     = sclk_reg;
    assign latch    = latch_reg;
    assign oe_n     = oe_n_reg;

endmodule
